// File: rtl/exec_stage.sv
// Execute stage: ALU, branch/jump resolution and load/store over a req/gnt/rvalid
// memory port, with a back-pressurable write-back result and a one-cycle redirect pulse.
module exec_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [2:0]             IN_KIND,
  input  logic [3:0]             IN_FUNC,
  input  logic [XLEN-1:0]        IN_PC,
  input  logic [XLEN-1:0]        IN_RS1_VAL,
  input  logic [XLEN-1:0]        IN_RS2_VAL,
  input  logic [XLEN-1:0]        IN_IMM,
  input  logic                   IN_USE_IMM,
  input  logic [4:0]             IN_RD,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [4:0]             OUT_RD,
  output logic [XLEN-1:0]        OUT_RESULT,
  output logic                   OUT_WB,
  output logic                   OUT_EXC,
  output logic                   REDIRECT_VALID,
  output logic [XLEN-1:0]        REDIRECT_PC,
  output logic                   MEM_REQ,
  output logic                   MEM_WE,
  output logic [ADDR_W-1:0]      MEM_ADDR,
  output logic [XLEN-1:0]        MEM_WDATA,
  output logic [XLEN/8-1:0]      MEM_BE,
  input  logic                   MEM_GNT,
  input  logic                   MEM_RVALID,
  input  logic [XLEN-1:0]        MEM_RDATA
);

  localparam int unsigned LANES = XLEN / 8;
  localparam int unsigned OFS_W = $clog2(LANES);
  localparam int unsigned SH_W  = $clog2(XLEN);
  localparam bit          HAS_D = (XLEN == 64);

  localparam logic [2:0] K_ALU = 3'd0, K_BR = 3'd1, K_JAL = 3'd2, K_JALR = 3'd3,
                         K_LD  = 3'd4, K_ST = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MREQ, S_MWAIT, S_DONE} state_t;
  state_t state, state_nx;

  logic accept;

  logic [XLEN-1:0]  op_b, alu_res, imm_off, br_target, jalr_target;
  logic [SH_W-1:0]  shamt;
  logic             alu_exc, br_taken, br_exc;
  logic [ADDR_W-1:0] mem_a;
  logic [1:0]       size;
  logic             size_ok, misal;
  logic [OFS_W-1:0] ofs;
  logic [LANES-1:0] be_c;
  logic [XLEN-1:0]  wdata_c;

  logic [XLEN-1:0]  dec_result, dec_target;
  logic             dec_wb, dec_exc, dec_taken, dec_mem;

  logic [1:0]       ld_size;
  logic             ld_uns;
  logic [OFS_W-1:0] ld_ofs;
  logic [XLEN-1:0]  rsh, ld_val;

  // ALU
  always_comb begin
    op_b    = IN_USE_IMM ? IN_IMM : IN_RS2_VAL;
    shamt   = op_b[SH_W-1:0];
    alu_res = '0;
    alu_exc = 1'b0;
    case (IN_FUNC)
      4'd0:    alu_res = IN_RS1_VAL + op_b;
      4'd1:    alu_res = IN_RS1_VAL - op_b;
      4'd2:    alu_res = IN_RS1_VAL & op_b;
      4'd3:    alu_res = IN_RS1_VAL | op_b;
      4'd4:    alu_res = IN_RS1_VAL ^ op_b;
      4'd5:    alu_res = IN_RS1_VAL << shamt;
      4'd6:    alu_res = IN_RS1_VAL >> shamt;
      4'd7:    alu_res = XLEN'($signed(IN_RS1_VAL) >>> shamt);
      4'd8:    alu_res = XLEN'($signed(IN_RS1_VAL) < $signed(op_b));
      4'd9:    alu_res = XLEN'(IN_RS1_VAL < op_b);
      default: alu_exc = 1'b1;
    endcase
  end

  // Branch condition and targets (PC is word-indexed, so the byte offset is scaled down)
  always_comb begin
    br_taken    = 1'b0;
    br_exc      = 1'b0;
    imm_off     = XLEN'($signed(IN_IMM) >>> 2);
    br_target   = IN_PC + imm_off;
    jalr_target = IN_RS1_VAL + imm_off;
    case (IN_FUNC)
      4'd0:    br_taken = (IN_RS1_VAL == IN_RS2_VAL);
      4'd1:    br_taken = (IN_RS1_VAL != IN_RS2_VAL);
      4'd4:    br_taken = ($signed(IN_RS1_VAL) <  $signed(IN_RS2_VAL));
      4'd5:    br_taken = ($signed(IN_RS1_VAL) >= $signed(IN_RS2_VAL));
      4'd6:    br_taken = (IN_RS1_VAL <  IN_RS2_VAL);
      4'd7:    br_taken = (IN_RS1_VAL >= IN_RS2_VAL);
      default: br_exc   = 1'b1;
    endcase
  end

  // Load/store address, alignment, lane enables and replicated write data
  always_comb begin
    mem_a   = IN_RS1_VAL[ADDR_W-1:0] + IN_IMM[ADDR_W-1:0];
    size    = IN_FUNC[1:0];
    size_ok = (size != 2'd3) || HAS_D;
    ofs     = mem_a[OFS_W-1:0];
    be_c    = LANES'((32'd1 << (32'd1 << size)) - 32'd1) << ofs;
    misal   = 1'b0;
    wdata_c = IN_RS2_VAL;
    case (size)
      2'd0: wdata_c = {LANES{IN_RS2_VAL[7:0]}};
      2'd1: begin
        misal   = mem_a[0];
        wdata_c = {(LANES/2){IN_RS2_VAL[15:0]}};
      end
      2'd2: begin
        misal   = |mem_a[1:0];
        wdata_c = {(LANES/4){IN_RS2_VAL[31:0]}};
      end
      default: misal = |mem_a[2:0];
    endcase
  end

  // Decode of the offered instruction into its result
  always_comb begin
    dec_result = '0;
    dec_target = br_target;
    dec_wb     = 1'b0;
    dec_exc    = 1'b0;
    dec_taken  = 1'b0;
    dec_mem    = 1'b0;
    case (IN_KIND)
      K_ALU: begin
        dec_result = alu_res;
        dec_wb     = ~alu_exc;
        dec_exc    = alu_exc;
      end
      K_BR: begin
        dec_taken = br_taken & ~br_exc;
        dec_exc   = br_exc;
      end
      K_JAL, K_JALR: begin
        dec_result = IN_PC + XLEN'(1);
        dec_wb     = 1'b1;
        dec_taken  = 1'b1;
        if (IN_KIND == K_JALR) dec_target = jalr_target;
      end
      K_LD, K_ST: begin
        if (!size_ok || misal) dec_exc = 1'b1;
        else                   dec_mem = 1'b1;
      end
      default: dec_exc = 1'b1;
    endcase
  end

  // Load data lane extraction and extension
  always_comb begin
    rsh    = MEM_RDATA >> {ld_ofs, 3'b000};
    ld_val = rsh;
    case (ld_size)
      2'd0:    ld_val = ld_uns ? XLEN'(rsh[7:0])  : XLEN'($signed(rsh[7:0]));
      2'd1:    ld_val = ld_uns ? XLEN'(rsh[15:0]) : XLEN'($signed(rsh[15:0]));
      2'd2:    ld_val = ld_uns ? XLEN'(rsh[31:0]) : XLEN'($signed(rsh[31:0]));
      default: ld_val = rsh;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = dec_mem ? S_MREQ : S_DONE;
      S_MREQ:  if (MEM_GNT) state_nx = MEM_WE ? S_DONE : S_MWAIT;
      S_MWAIT: if (MEM_RVALID) state_nx = S_DONE;
      S_DONE: begin
        if (OUT_READY) state_nx = accept ? (dec_mem ? S_MREQ : S_DONE) : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = (state == S_IDLE) || ((state == S_DONE) && OUT_READY);
    MEM_REQ   = (state == S_MREQ);
    OUT_VALID = (state == S_DONE);
    accept    = IN_VALID && IN_READY;
  end

  // Result, redirect and memory request registers; only move on acceptance or load response
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      OUT_RD         <= '0;
      OUT_RESULT     <= '0;
      OUT_WB         <= 1'b0;
      OUT_EXC        <= 1'b0;
      REDIRECT_VALID <= 1'b0;
      REDIRECT_PC    <= '0;
      MEM_WE         <= 1'b0;
      MEM_ADDR       <= '0;
      MEM_WDATA      <= '0;
      MEM_BE         <= '0;
      ld_size        <= '0;
      ld_uns         <= 1'b0;
      ld_ofs         <= '0;
    end else begin
      REDIRECT_VALID <= accept && dec_taken;
      if (accept) begin
        OUT_RD     <= IN_RD;
        OUT_RESULT <= dec_result;
        OUT_WB     <= dec_wb;
        OUT_EXC    <= dec_exc;
        if (dec_taken) REDIRECT_PC <= dec_target;
        if (dec_mem) begin
          MEM_WE    <= (IN_KIND == K_ST);
          MEM_ADDR  <= mem_a;
          MEM_WDATA <= wdata_c;
          MEM_BE    <= be_c;
          ld_size   <= size;
          ld_uns    <= IN_FUNC[2];
          ld_ofs    <= ofs;
        end
      end else if ((state == S_MWAIT) && MEM_RVALID) begin
        OUT_RESULT <= ld_val;
        OUT_WB     <= 1'b1;
      end
    end
  end

endmodule

// File: doc/exec_stage.md
# exec_stage

Parametrised execute stage for the RISC-V core. It takes one decoded instruction at a time over a valid/ready handshake and performs ALU operations, branch/jump resolution and load/store. Loads and stores go through a multi-cycle memory request/grant/response interface. Results are presented on a registered, back-pressurable write-back port, and taken control transfers produce a one-cycle redirect pulse to fetch.

## Interface
- XLEN, 32: datapath width; must be 32 or 64.
- ADDR_W, 10: memory byte-address width.
- LANES, XLEN/8: byte lanes (derived); OFS_W = log2(LANES).
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  instruction offered.
- IN_READY  out  1  stage accepts this cycle.
- IN_KIND  in  3  0 ALU, 1 BRANCH, 2 JAL, 3 JALR, 4 LOAD, 5 STORE; 6–7 illegal.
- IN_FUNC  in  4  ALU op, branch condition or access size (see Operation).
- IN_PC  in  XLEN  word-indexed PC.
- IN_RS1_VAL, IN_RS2_VAL, IN_IMM  in  XLEN  operands and sign-extended immediate.
- IN_USE_IMM  in  1  ALU operand B is IN_IMM instead of IN_RS2_VAL.
- IN_RD  in  5  destination register.
- OUT_VALID  out  1  result held.
- OUT_READY  in  1  consumer takes result.
- OUT_RD  out  5 / OUT_RESULT  out  XLEN / OUT_WB  out  1 / OUT_EXC  out  1.
- REDIRECT_VALID  out  1 / REDIRECT_PC  out  XLEN.
- MEM_REQ  out  1 / MEM_WE  out  1 / MEM_ADDR  out  ADDR_W / MEM_WDATA  out  XLEN / MEM_BE  out  LANES.
- MEM_GNT  in  1 / MEM_RVALID  in  1 / MEM_RDATA  in  XLEN.

## Operation
- FSM states:
  - IDLE: IN_READY=1.
  - MREQ: MEM_REQ=1, waiting for MEM_GNT.
  - MWAIT: waiting for MEM_RVALID.
  - DONE: OUT_VALID=1.
- In DONE, IN_READY=OUT_READY. Accepting an instruction in DONE while OUT_READY=1 is legal (back-to-back).
- ALU ops (IN_FUNC): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU; 10–15 give OUT_EXC=1.
  - Shift amount is the low log2(XLEN) bits of operand B.
  - OUT_WB=1. Acceptance goes straight to DONE.
- Control transfers:
  - BRANCH func uses RISC-V funct3: 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU. Other values give OUT_EXC=1 and not-taken.
  - Target = IN_PC + (IN_IMM >>> 2), signed and modulo 2^XLEN. JALR target = IN_RS1_VAL + (IN_IMM >>> 2).
  - JAL/JALR: OUT_RESULT = IN_PC+1 and OUT_WB=1. BRANCH: OUT_WB=0.
  - When taken, REDIRECT_VALID pulses for exactly one cycle (the cycle after acceptance) with REDIRECT_PC = target. Not-taken: no pulse.
- Load/store:
  - Byte address = IN_RS1_VAL + IN_IMM, truncated to ADDR_W.
  - IN_FUNC[1:0] size: 0 byte, 1 half, 2 word, 3 dword (XLEN=64 only). IN_FUNC[2] = unsigned (loads only).
  - Misaligned (address not a multiple of the size) or illegal size: no memory request; DONE with OUT_EXC=1, OUT_WB=0.
  - MEM_BE = ((1<<bytes)−1) << addr[OFS_W−1:0].
  - MEM_WDATA = IN_RS2_VAL replicated into the addressed lanes.
  - MEM_ADDR, MEM_WE, MEM_BE and MEM_WDATA are held stable while MEM_REQ=1.
  - STORE: MREQ, then on MEM_GNT go to DONE with OUT_WB=0.
  - LOAD: MREQ, then on MEM_GNT go to MWAIT; on MEM_RVALID capture the addressed lanes, sign- or zero-extend, and go to DONE with OUT_WB=1.
  - MEM_RVALID outside MWAIT is ignored.
- OUT_EXC and OUT_WB are never both 1. IN_KIND 6–7 gives DONE with OUT_EXC=1.

## Timing
- Reset (asynchronous, RSTN=0): state IDLE.
  - All outputs 0, except IN_READY=1.
  - Reset mid-transaction abandons it: MEM_REQ drops immediately and no result is produced.
- Latency from acceptance edge to OUT_VALID:
  - ALU, branch, jump, exception: 1 cycle.
  - Store: 1 + grant wait.
  - Load: 1 + grant wait + response wait (minimum 3 cycles with GNT and RVALID each in their first eligible cycle).
- MEM_REQ rises the cycle after acceptance. The request and its grant are a single cycle handshake.
- OUT_* stay constant while OUT_VALID=1 and OUT_READY=0.
- Throughput: one ALU op per cycle under OUT_READY=1.

## Test plan
- ALU throughput: ADD 5+(−7) then SRA 0x80000000 by 4, issued on consecutive cycles with OUT_READY=1 → OUT_RESULT 0xFFFFFFFE then 0xF8000000 on consecutive cycles. IN_READY stays 1.
- Branches: BLT rs1=−1, rs2=1, pc=0x100, imm=16 → REDIRECT_PC 0x104, pulse width 1. BLTU with the same operands → no pulse, OUT_WB=0.
- JALR: rs1=0x200, imm=−8, pc=0x40 → REDIRECT_PC 0x1FE, OUT_RESULT 0x41, OUT_WB=1.
- Store byte then load: SB of 0xAB at address 0x13 → MEM_BE=4'b1000, MEM_WDATA=0xABABABAB, MEM_REQ held 3 cycles until GNT. Then LB at 0x13 returning 0xAB000000 → OUT_RESULT 0xFFFFFFAB; LBU → 0x000000AB.
- Misaligned access and back-pressure: LW at 0x2 → no MEM_REQ, OUT_EXC=1. With OUT_READY held 0 for 4 cycles, the outputs are stable and IN_READY=0.
- Reset: assert RSTN low while in MWAIT → MEM_REQ and OUT_VALID are 0 within the same cycle. A late MEM_RVALID after release is ignored.
